// File: rtl/mbe_mac_seq.sv
// mbe_mac_seq: iterative radix-4 Modified-Booth signed multiply-accumulate.
// Retires one Booth digit per clock (WIDTH/2 cycles per product), then
// optionally folds the product into a signed accumulator.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   a, b                signed multiplicand / multiplier (WIDTH bits)
//   acc_clr, acc_en     accumulator control, sampled with the operands
//   out_valid/out_ready result handshake (out_valid in DONE)
//   p                   signed product a*b (2*WIDTH bits)
//   acc                 signed accumulator (ACC_WIDTH bits)
//   busy                high in CALC or DONE
//   ovf                 sticky accumulator overflow flag
//
// Build option: define MBE_MAC_SAT_EN for a saturating accumulator with a
// sticky ovf flag; without it the accumulator wraps and ovf is 0.
module mbe_mac_seq #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2 * WIDTH + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   acc_clr,
  input  logic                   acc_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     p,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   busy,
  output logic                   ovf
);

  localparam int PW   = 2 * WIDTH;
  localparam int NDIG = WIDTH / 2;
  localparam int KW   = $clog2(WIDTH);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("mbe_mac_seq: WIDTH must be even and >= 4");
  end
  if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc_width
    $error("mbe_mac_seq: ACC_WIDTH must be >= 2*WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 clr_q, clr_d, en_q, en_d;
  logic [KW-1:0]        k_q, k_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic [PW-1:0]        p_q, p_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  logic [WIDTH:0]       b_ext;
  logic [KW:0]          shamt;
  logic [2:0]           code;
  logic [PW-1:0]        a_ext, pp, prod_sum;
  logic [ACC_WIDTH-1:0] base, prod_x, acc_sum, acc_new;
  logic                 ov;

  always_comb begin
    // Datapath: current Booth digit {b[2k+1], b[2k], b[2k-1]}, b[-1] = 0
    b_ext    = {b_q, 1'b0};
    shamt    = {k_q, 1'b0};
    code     = 3'(b_ext >> shamt);
    a_ext    = PW'(signed'(a_q));
    case (code)
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext << 1;
      3'b100:         pp = -(a_ext << 1);
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
    prod_sum = prod_q + (pp << shamt);

    base     = clr_q ? '0 : acc_q;
    prod_x   = ACC_WIDTH'(signed'(prod_sum));
    acc_sum  = base + prod_x;
    // Signed overflow: addends agree in sign, result disagrees
    ov       = (base[ACC_WIDTH-1] == prod_x[ACC_WIDTH-1]) &&
               (acc_sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
`ifdef MBE_MAC_SAT_EN
    if (ov) acc_new = base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else    acc_new = acc_sum;
`else
    acc_new  = acc_sum;
`endif

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    clr_d   = clr_q;
    en_d    = en_q;
    k_d     = k_q;
    prod_d  = prod_q;
    p_d     = p_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          clr_d   = acc_clr;
          en_d    = acc_en;
          k_d     = '0;
          prod_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        prod_d = prod_sum;
        k_d    = k_q + 1'b1;
        if (k_q == KW'(NDIG - 1)) begin
          p_d     = prod_sum;
          state_d = DONE;
          if (en_q) begin
            acc_d = acc_new;
`ifdef MBE_MAC_SAT_EN
            if (ov)         ovf_d = 1'b1;
            else if (clr_q) ovf_d = 1'b0;
`endif
          end else if (clr_q) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifndef MBE_MAC_SAT_EN
    ovf_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      k_q     <= '0;
      prod_q  <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      k_q     <= k_d;
      prod_q  <= prod_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p         = p_q;
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule
